seq_stream_ctrl: RTL and testbench
==================================

// Module: seq_stream_ctrl
// PURPOSE
//  Run controller for the 101101 sequence detector. Loads a pattern word and feeds it to the
//  detector one bit per tick, MSB-first, from pattern[len-1] down to pattern[0].
//  Paces the detector with one-cycle step enables, counts Z detections and reports the
//  index of the first hit.
//  Sits between the clock-divider tick and the detector, replacing the manual step button.
// PARAMETERS
//  PW     16  pattern width in bits (maximum run length)
//  CNT_W  5   width of len, hit_count and first_hit_idx; must hold PW
// PORTS
//  clk            in   1      system clock; single clock domain
//  reset          in   1      synchronous, active-high
//  tick           in   1      one-cycle pacing pulse from the clock divider
//  start          in   1      begin a run; sampled only in IDLE
//  abort          in   1      terminate the current run
//  pattern        in   PW     bit stream to feed
//  len            in   CNT_W  number of bits to feed; 0..PW
//  mode_in        in   1      detector mode: 1 = Mealy, 0 = Moore (shared constant)
//  z_in           in   1      detector Z output
//  x_out          out  1      detector X input
//  m_out          out  1      detector M input; latched at start
//  step_en        out  1      detector clock enable; one cycle per bit
//  det_reset      out  1      one-cycle detector clear
//  busy           out  1      high from start accept until DONE exits
//  done           out  1      one-cycle pulse at run end
//  hit_count      out  CNT_W  detections in the last or current run
//  first_hit_idx  out  CNT_W  feed index (0-based) of the bit on which the first Z occurred
//  hit_valid      out  1      first_hit_idx is valid
// BEHAVIOUR
//  Reset (synchronous, wins over all inputs):
//  - State is IDLE; every output is 0.
//  FSM states: IDLE, CLR, WAIT_TICK, STEP, CHECK, DONE.
//  - IDLE: if start=1, capture pattern, len and mode_in, then go to CLR.
//    Also clear hit_count, first_hit_idx and hit_valid.
//  - CLR: det_reset=1 for exactly one cycle. If len=0 go to DONE, else go to WAIT_TICK.
//  - WAIT_TICK: hold x_out = current bit. On tick=1 go to STEP. A tick seen in any other
//    state is dropped, not queued.
//  - STEP: step_en=1 for exactly one cycle. In Mealy mode, sample z_in in this cycle.
//  - CHECK: in Moore mode, sample z_in in this cycle.
//    - A sampled Z=1 increments hit_count.
//    - On the first hit, first_hit_idx takes the feed index and hit_valid goes to 1.
//    - Advance the bit pointer. When len bits have been fed go to DONE, else go to WAIT_TICK.
//  - DONE: done=1 for one cycle, then go to IDLE. busy=1 in every state except IDLE.
//  x_out and m_out:
//  - x_out is stable from WAIT_TICK entry through CHECK, and is 0 in IDLE.
//  - m_out is held for the whole run. mode_in changes mid-run are ignored.
//  Latency: bit k enters the detector on the STEP cycle that follows the (k+1)-th accepted tick.
//  start, abort and hit results:
//  - start while busy is ignored, and the captured inputs are unchanged.
//  - abort=1 in any non-IDLE state goes to IDLE next cycle, with det_reset=1 on that cycle
//    and done not pulsed. Hit outputs keep their values.
//  - abort in IDLE is a no-op. If abort and start are both 1 in IDLE, abort wins and the run
//    does not start.
//  - hit_count and first_hit_idx hold after DONE until the next accepted start.
//  - hit_count cannot exceed PW/3 for PW=16, so saturation is not required.
//  - len > PW is clamped to PW at capture.
// STRUCTURE
//  - seq_ctrl_pkg holds: the state encoding (localparams), MODE_MEALY=1'b1, MODE_MOORE=1'b0,
//    and the PW default.
//  - Single module, no sub-modules. The bit select is a PW:1 mux on the down-counting pointer.
// TESTING
//  - Moore, pattern=0x002D, len=6, ticks every 10 cycles.
//    -> 6 step_en pulses; hit_count=1; first_hit_idx=5; hit_valid=1; one done pulse.
//  - Mealy, pattern=0x016D, len=9 (overlapping 101101101).
//    -> hit_count=2; first_hit_idx=5; Z sampled in the STEP cycle.
//  - Moore, pattern=0xFFFF, len=16.
//    -> hit_count=0; hit_valid=0; done after the 16th CHECK.
//  - start pulsed again mid-run with a different pattern; toggle mode_in.
//    -> ignored: original run completes and m_out is unchanged.
//  - abort during the 3rd WAIT_TICK.
//    -> next cycle IDLE with busy=0 and det_reset=1; done not pulsed; no further step_en.
//  - reset asserted in STEP with len=0; then start.
//    -> all outputs 0 the next cycle. The len=0 start gives CLR then DONE, with 0 step_en pulses.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared constants for the sequence-detector run controller.
package seq_ctrl_pkg;

    localparam int PW_DEF    = 16;
    localparam int CNT_W_DEF = 5;

    // Detector mode encoding, as seen on the detector's M input
    localparam logic MODE_MEALY = 1'b1;
    localparam logic MODE_MOORE = 1'b0;

    // Controller state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CLR       = 3'd1;
    localparam logic [2:0] ST_WAIT_TICK = 3'd2;
    localparam logic [2:0] ST_STEP      = 3'd3;
    localparam logic [2:0] ST_CHECK     = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_CLR       = ST_CLR,
        S_WAIT_TICK = ST_WAIT_TICK,
        S_STEP      = ST_STEP,
        S_CHECK     = ST_CHECK,
        S_DONE      = ST_DONE
    } state_t;

endpackage

// File: rtl/seq_stream_ctrl.sv
// Run controller for the 101101 detector: feeds a captured pattern MSB-first,
// one bit per accepted tick, and tallies the detector's Z hits.
module seq_stream_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int PW    = PW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    input  logic [PW-1:0]    pattern,
    input  logic [CNT_W-1:0] len,
    input  logic             mode_in,
    input  logic             z_in,
    output logic             x_out,
    output logic             m_out,
    output logic             step_en,
    output logic             det_reset,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] first_hit_idx,
    output logic             hit_valid
);

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(PW);

    state_t           state;
    logic [PW-1:0]    pat_r;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] ptr;      // index into pat_r of the bit currently on x_out

    logic [CNT_W-1:0] len_clamped;
    logic [CNT_W-1:0] ptr_dec;
    logic [CNT_W-1:0] feed_idx;
    logic             first_bit;
    logic             next_bit;
    logic             sample;
    logic             hit;

    // PW:1 mux selecting one pattern bit by pointer value
    function automatic logic bit_at(input logic [PW-1:0] p, input logic [CNT_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < PW; i++) begin
            if (idx == CNT_W'(i)) b = p[i];
        end
        return b;
    endfunction

    // Bit selection, feed index and Z sampling window
    always_comb begin
        len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
        ptr_dec     = ptr - ONE;
        feed_idx    = len_r - ptr - ONE;
        first_bit   = bit_at(pat_r, len_r - ONE);
        next_bit    = bit_at(pat_r, ptr_dec);
        // Mealy Z is valid while the step enable is high; Moore Z only after the step lands
        sample      = ((state == S_STEP)  && (m_out == MODE_MEALY)) ||
                      ((state == S_CHECK) && (m_out == MODE_MOORE));
        hit         = sample && z_in;
    end

    // Run FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pat_r         <= '0;
            len_r         <= '0;
            ptr           <= '0;
            x_out         <= 1'b0;
            m_out         <= 1'b0;
            step_en       <= 1'b0;
            det_reset     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            hit_count     <= '0;
            first_hit_idx <= '0;
            hit_valid     <= 1'b0;
        end else begin
            step_en   <= 1'b0;
            det_reset <= 1'b0;
            done      <= 1'b0;

            if (abort && (state != S_IDLE)) begin
                // Abandon the run: clear the detector, keep hit results, no done pulse
                state     <= S_IDLE;
                det_reset <= 1'b1;
                busy      <= 1'b0;
                x_out     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            pat_r         <= pattern;
                            len_r         <= len_clamped;
                            m_out         <= mode_in;
                            hit_count     <= '0;
                            first_hit_idx <= '0;
                            hit_valid     <= 1'b0;
                            det_reset     <= 1'b1;
                            busy          <= 1'b1;
                            state         <= S_CLR;
                        end
                    end
                    S_CLR: begin
                        ptr <= len_r - ONE;
                        if (len_r == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            x_out <= first_bit;
                            state <= S_WAIT_TICK;
                        end
                    end
                    S_WAIT_TICK: begin
                        if (tick) begin
                            step_en <= 1'b1;
                            state   <= S_STEP;
                        end
                    end
                    S_STEP: begin
                        state <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (ptr == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            ptr   <= ptr_dec;
                            x_out <= next_bit;
                            state <= S_WAIT_TICK;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        x_out <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        x_out <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase

                // hit can only be set in STEP/CHECK, so this never collides with the IDLE clear
                if (hit) begin
                    hit_count <= hit_count + ONE;
                    if (!hit_valid) begin
                        first_hit_idx <= feed_idx;
                        hit_valid     <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Bench for seq_stream_ctrl: a windowed 101101 detector model drives z_in, and
// each run is compared against a sliding-window count over the fed bit sequence.
module tb_seq_stream_ctrl;

    localparam int PW    = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset, tick, start, abort, mode_in, z_in;
    logic [PW-1:0]    pattern;
    logic [CNT_W-1:0] len;
    logic             x_out, m_out, step_en, det_reset, busy, done, hit_valid;
    logic [CNT_W-1:0] hit_count, first_hit_idx;

    int n_checks = 0;
    int n_fail   = 0;

    seq_stream_ctrl #(.PW(PW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .abort(abort),
        .pattern(pattern), .len(len), .mode_in(mode_in), .z_in(z_in),
        .x_out(x_out), .m_out(m_out), .step_en(step_en), .det_reset(det_reset),
        .busy(busy), .done(done), .hit_count(hit_count),
        .first_hit_idx(first_hit_idx), .hit_valid(hit_valid)
    );

    always #5 clk = ~clk;

    // Detector model: remembers the last six stepped bits since its last clear
    logic [5:0] hist;
    int         nbits;
    always @(posedge clk) begin
        if (reset || det_reset) begin
            hist  <= '0;
            nbits <= 0;
        end else if (step_en) begin
            hist  <= {hist[4:0], x_out};
            nbits <= (nbits < 6) ? nbits + 1 : 6;
        end
    end
    always_comb begin
        if (m_out) z_in = (nbits >= 5) && (hist[4:0] == 5'b10110) && x_out;
        else       z_in = (nbits >= 6) && (hist == 6'b101101);
    end

    // Observation of step pulses, done pulses, fed bits and held mode
    logic tick_seen = 1'b0;
    logic exp_m     = 1'b0;
    int   step_cnt  = 0;
    int   done_cnt  = 0;
    logic fed_q[$];

    always @(posedge clk) tick_seen <= tick;

    always @(negedge clk) begin
        if (step_en) begin
            step_cnt++;
            fed_q.push_back(x_out);
            n_checks++;
            if (tick_seen !== 1'b1) begin
                n_fail++;
                $display("FAIL step_latency: step_en without tick on previous cycle (tick=%b)", tick_seen);
            end
            n_checks++;
            if (m_out !== exp_m) begin
                n_fail++;
                $display("FAIL m_out_held: got %b want %b", m_out, exp_m);
            end
        end
        if (done) done_cnt++;
    end

    // Reference: bits fed k=0..L-1 are pat[L-1-k]; a hit is a 101101 window ending at k
    function automatic void ref_run(input logic [15:0] pat, input int l_raw, input int stop,
                                    output int cnt, output int first, output logic vld,
                                    output logic [15:0] seq, output int nfed);
        int   L;
        logic [5:0] win;
        L = (l_raw > PW) ? PW : l_raw;
        nfed = (stop < L) ? stop : L;
        cnt = 0; first = 0; vld = 1'b0; seq = '0; win = '0;
        for (int k = 0; k < nfed; k++) begin
            seq[k] = pat[L-1-k];
            win = {win[4:0], pat[L-1-k]};
            if (k >= 5 && win == 6'b101101) begin
                cnt++;
                if (!vld) first = k;
                vld = 1'b1;
            end
        end
    endfunction

    task automatic clear_obs();
        step_cnt = 0;
        done_cnt = 0;
        fed_q.delete();
    endtask

    task automatic check_results(input string name, input logic [15:0] pat, input int l,
                                 input int stop, input int exp_done);
        int cnt, first, nfed;
        logic vld;
        logic [15:0] seq, got;
        ref_run(pat, l, stop, cnt, first, vld, seq, nfed);
        got = '0;
        for (int i = 0; i < fed_q.size() && i < 16; i++) got[i] = fed_q[i];
        n_checks++;
        if (step_cnt !== nfed) begin n_fail++; $display("FAIL %s step_count: got %0d want %0d", name, step_cnt, nfed); end
        n_checks++;
        if (got !== seq) begin n_fail++; $display("FAIL %s fed_bits: got %h want %h", name, got, seq); end
        n_checks++;
        if (done_cnt !== exp_done) begin n_fail++; $display("FAIL %s done_pulses: got %0d want %0d", name, done_cnt, exp_done); end
        n_checks++;
        if (hit_count !== CNT_W'(cnt)) begin n_fail++; $display("FAIL %s hit_count: got %0d want %0d", name, hit_count, cnt); end
        n_checks++;
        if (first_hit_idx !== CNT_W'(first)) begin n_fail++; $display("FAIL %s first_hit_idx: got %0d want %0d", name, first_hit_idx, first); end
        n_checks++;
        if (hit_valid !== vld) begin n_fail++; $display("FAIL %s hit_valid: got %b want %b", name, hit_valid, vld); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after: got %b want 0", name, busy); end
    endtask

    // period 0 = random ticks; disturb = re-pulse start with other inputs and wiggle mode_in
    task automatic run_case(input string name, input logic [15:0] pat, input int l,
                            input logic md, input int period, input bit disturb);
        int cyc;
        @(negedge clk);
        clear_obs();
        pattern = pat; len = l[4:0]; mode_in = md; exp_m = md; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin
            if (period == 0) tick = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
            else             tick = (cyc % period == 0) ? 1'b1 : 1'b0;
            if (disturb) begin
                mode_in = ~mode_in;
                start   = (cyc == 25) ? 1'b1 : 1'b0;
                pattern = ~pat;
                len     = 5'd3;
            end
            @(negedge clk);
            cyc++;
        end
        tick = 1'b0; start = 1'b0;
        if (cyc >= 2000) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: no done within 2000 cycles", name);
        end
        @(negedge clk);
        check_results(name, pat, l, 99, 1);
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b0; start = 1'b1; abort = 1'b0;
        pattern = 16'h002D; len = 5'd6; mode_in = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({x_out, m_out, step_en, det_reset, busy, done, hit_count, first_hit_idx, hit_valid} !== 17'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {x_out, m_out, step_en, det_reset, busy, done, hit_count, first_hit_idx, hit_valid});
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_moore_basic();
        run_case("moore_2d", 16'h002D, 6, 1'b0, 10, 1'b0);
    endtask

    task automatic test_mealy_overlap();
        run_case("mealy_16d", 16'h016D, 9, 1'b1, 7, 1'b0);
        run_case("moore_16d", 16'h016D, 9, 1'b0, 4, 1'b0);
    endtask

    task automatic test_no_hits();
        run_case("moore_ffff", 16'hFFFF, 16, 1'b0, 3, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_case("busy_start", 16'hB6D0, 12, 1'b1, 6, 1'b1);
    endtask

    task automatic test_len_edges();
        run_case("len_over", 16'h2DAB, 31, 1'b0, 2, 1'b0);
        run_case("len_full", 16'hB6DB, 16, 1'b1, 2, 1'b0);
        run_case("len_zero", 16'hFFFF, 0, 1'b1, 2, 1'b0);
    endtask

    task automatic test_abort_idle();
        @(negedge clk);
        clear_obs();
        start = 1'b1; abort = 1'b1; pattern = 16'h002D; len = 5'd6;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if ({busy, det_reset} !== 2'b00) begin
            n_fail++; $display("FAIL abort_start_idle: busy,det_reset got %b want 00", {busy, det_reset});
        end
    endtask

    // Abort once 'after' bits have been fed, while waiting for the next tick
    task automatic test_abort(input string name, input logic [15:0] pat, input int after);
        int cyc;
        @(negedge clk);
        clear_obs();
        pattern = pat; len = 5'd16; mode_in = 1'b0; exp_m = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (step_cnt < after && cyc < 500) begin
            tick = (cyc % 8 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        tick = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({busy, det_reset, done} !== 3'b010) begin
            n_fail++; $display("FAIL %s abort_next: busy,det_reset,done got %b want 010", name, {busy, det_reset, done});
        end
        for (int i = 0; i < 60; i++) begin
            tick = (i % 5 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        tick = 1'b0;
        check_results(name, pat, 16, after, 0);
    endtask

    task automatic test_reset_len0();
        int cyc;
        @(negedge clk);
        clear_obs();
        pattern = 16'hA5A5; len = 5'd16; mode_in = 1'b1; exp_m = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (step_en !== 1'b1 && cyc < 200) begin
            tick = (cyc % 5 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        tick = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({x_out, m_out, step_en, det_reset, busy, done, hit_count, first_hit_idx, hit_valid} !== 17'b0) begin
            n_fail++;
            $display("FAIL reset_in_step: got %b want all zero",
                     {x_out, m_out, step_en, det_reset, busy, done, hit_count, first_hit_idx, hit_valid});
        end
        clear_obs();
        pattern = 16'hFFFF; len = 5'd0; start = 1'b1; tick = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({det_reset, busy, done} !== 3'b110) begin
            n_fail++; $display("FAIL len0_clr: det_reset,busy,done got %b want 110", {det_reset, busy, done});
        end
        @(negedge clk);
        n_checks++;
        if ({det_reset, busy, done} !== 3'b011) begin
            n_fail++; $display("FAIL len0_done: det_reset,busy,done got %b want 011", {det_reset, busy, done});
        end
        @(negedge clk);
        tick = 1'b0;
        n_checks++;
        if ({busy, step_cnt != 0} !== 2'b00) begin
            n_fail++; $display("FAIL len0_idle: busy=%b steps=%0d want 0,0", busy, step_cnt);
        end
    endtask

    task automatic test_random();
        logic [15:0] p;
        int l, per;
        logic md;
        for (int r = 0; r < 14; r++) begin
            p = 16'($urandom);
            if ($urandom_range(0, 1) == 1) p[5:0] = 6'b101101;
            if ($urandom_range(0, 2) == 0) p = {p[5:0], p[5:0], p[3:0]};
            l   = $urandom_range(0, 20);
            md  = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
            per = $urandom_range(0, 5);
            run_case("random", p, l, md, per, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        run_case("b2b_a", 16'hB6DB, 16, 1'b1, 1, 1'b0);
        run_case("b2b_b", 16'h5B6D, 15, 1'b0, 1, 1'b0);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; abort = 1'b0;
        pattern = '0; len = '0; mode_in = 1'b0;
        test_reset();
        test_moore_basic();
        test_mealy_overlap();
        test_no_hits();
        test_start_while_busy();
        test_len_edges();
        test_abort_idle();
        test_abort("abort_3rd_wait", 16'hB6D5, 2);
        test_abort("abort_after_hit", 16'hB4D5, 8);
        test_reset_len0();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
